shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/alu_pkg.sv | 29 ++
 rtl/shifter.sv | 23 ++
 rtl/shift_sequencer.sv | 107 ++++++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer FSM states, shift-mode encodings and the
// per-step shift-in bit selection.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    // Reserved mode falls into the default branch and behaves as logical.
    function automatic logic shift_in_bit(input logic [1:0] mode, input logic is_left,
                                          input logic msb, input logic lsb);
        logic b;
        b = 1'b0;
        case (mode)
            MODE_ARITH:  b = is_left ? 1'b0 : msb;
            MODE_ROTATE: b = is_left ? msb : lsb;
            default:     b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shifter.sv
// Single-step 1-bit shifter: moves data one place toward the chosen end,
// fills the vacated bit with shift_in and reports the bit that fell off.
module shifter #(
    parameter int SIZE = 8
) (
    input  logic            is_left_shift,
    input  logic            shift_in,
    input  logic [SIZE-1:0] data,
    output logic [SIZE-1:0] data_out,
    output logic            shift_out
);

    always_comb begin
        if (is_left_shift) begin
            data_out  = {data[SIZE-2:0], shift_in};
            shift_out = data[SIZE-1];
        end else begin
            data_out  = {shift_in, data[SIZE-1:1]};
            shift_out = data[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: captures an operand and performs one 1-bit
// shift per clock through a single shifter instance until the count expires.
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int AW   = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_left_shift,
    input  logic [1:0]      mode,
    input  logic [AW-1:0]   amount,
    input  logic [SIZE-1:0] data_in,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] data_out,
    output logic            shift_out
);

    localparam logic [AW-1:0] SIZE_AW = AW'(SIZE);

    state_e          state_q, state_d;
    logic [AW-1:0]   count_q, count_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            so_q, so_d;
    logic            dir_q, dir_d;
    logic [1:0]      mode_q, mode_d;

    logic            accept;
    logic [AW-1:0]   amt_sat;
    logic            sh_in;
    logic [SIZE-1:0] sh_data;
    logic            sh_so;

    assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign amt_sat = (amount > SIZE_AW) ? SIZE_AW : amount;

    // Shifter is fed purely from captured registers.
    assign sh_in = shift_in_bit(mode_q, dir_q, data_q[SIZE-1], data_q[0]);

    shifter #(.SIZE(SIZE)) u_shifter (
        .is_left_shift (dir_q),
        .shift_in      (sh_in),
        .data          (data_q),
        .data_out      (sh_data),
        .shift_out     (sh_so)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            so_q    <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= MODE_LOGICAL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            so_q    <= so_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = (amt_sat == '0) ? ST_DONE : ST_SHIFT;
                else        state_d = ST_IDLE;
            end
            ST_SHIFT: if (count_q == AW'(1)) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        so_d    = so_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        if (accept) begin
            count_d = amt_sat;
            data_d  = data_in;
            so_d    = 1'b0;
            dir_d   = is_left_shift;
            mode_d  = mode;
        end else if (state_q == ST_SHIFT) begin
            count_d = count_q - AW'(1);
            data_d  = sh_data;
            so_d    = sh_so;
        end
    end

    always_comb begin
        busy      = (state_q == ST_SHIFT);
        done      = (state_q == ST_DONE);
        data_out  = data_q;
        shift_out = so_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (SIZE=8): stimulus pushes hand-computed
// results, a monitor pops and checks them whenever done is presented.
module tb_shift_sequencer;

    localparam int SIZE = 8;
    localparam int AW   = 4;

    typedef struct {
        logic [SIZE-1:0] data;
        logic            so;
        int              done_cyc;
        int              busy_cyc;
        string           name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            is_left_shift = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [AW-1:0]   amount = '0;
    logic [SIZE-1:0] data_in = '0;
    logic            busy, done, shift_out;
    logic [SIZE-1:0] data_out;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    shift_sequencer #(.SIZE(SIZE), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .is_left_shift (is_left_shift),
        .mode          (mode),
        .amount        (amount),
        .data_in       (data_in),
        .busy          (busy),
        .done          (done),
        .data_out      (data_out),
        .shift_out     (shift_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts busy cycles and checks each done against the scoreboard.
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        chk({e.name, "_data"}, int'(data_out), int'(e.data));
                        chk({e.name, "_so"}, int'(shift_out), int'(e.so));
                        chk({e.name, "_done_cyc"}, cyc, e.done_cyc);
                        chk({e.name, "_busy_cycles"}, busy_cnt, e.busy_cyc);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Drive one request from a negedge; start drops after the accept edge.
    task automatic issue(input string name, input logic dir, input logic [1:0] md,
                         input logic [AW-1:0] amt, input logic [SIZE-1:0] din,
                         input logic [SIZE-1:0] exp_d, input logic exp_so, input int cnt);
        exp_t e;
        @(negedge clk);
        is_left_shift = dir;
        mode          = md;
        amount        = amt;
        data_in       = din;
        start         = 1'b1;
        e.data = exp_d; e.so = exp_so; e.done_cyc = cyc + 1 + cnt; e.busy_cyc = cnt; e.name = name;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin : stim
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_so", int'(shift_out), 0);
        rst_n = 1'b1;

        issue("ll3", 1'b1, 2'b00, 4'd3, 8'b1001_0110, 8'b1011_0000, 1'b0, 3);
        drain("ll3");
        issue("ar2", 1'b0, 2'b01, 4'd2, 8'b1000_0001, 8'b1110_0000, 1'b0, 2);
        drain("ar2");
        issue("rr1", 1'b0, 2'b10, 4'd1, 8'b0000_0011, 8'b1000_0001, 1'b1, 1);
        drain("rr1");
        issue("amt0", 1'b1, 2'b00, 4'd0, 8'hA5, 8'hA5, 1'b0, 0);
        drain("amt0");
        issue("lr12", 1'b0, 2'b00, 4'd12, 8'h80, 8'h00, 1'b1, 8);
        drain("lr12");
        issue("rl15", 1'b1, 2'b10, 4'd15, 8'h5B, 8'h5B, 1'b1, 8);
        drain("rl15");
        issue("al1", 1'b1, 2'b01, 4'd1, 8'hC1, 8'h82, 1'b1, 1);
        drain("al1");
        issue("rsvd4", 1'b0, 2'b11, 4'd4, 8'hFF, 8'h0F, 1'b1, 4);
        drain("rsvd4");
        issue("ar3", 1'b0, 2'b01, 4'd3, 8'h40, 8'h08, 1'b0, 3);
        drain("ar3");

        // start with new operands while shifting must be ignored
        issue("ign", 1'b1, 2'b00, 4'd3, 8'b1001_0110, 8'b1011_0000, 1'b0, 3);
        is_left_shift = 1'b0; mode = 2'b10; amount = 4'd1; data_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ign");

        // back-to-back: start held through SHIFT and DONE; operands change mid-shift
        @(negedge clk);
        is_left_shift = 1'b1; mode = 2'b00; amount = 4'd2; data_in = 8'h01; start = 1'b1;
        e.data = 8'h04; e.so = 1'b0; e.done_cyc = cyc + 1 + 2; e.busy_cyc = 2; e.name = "b2b_a";
        q.push_back(e);
        e.data = 8'h80; e.so = 1'b1; e.done_cyc = cyc + 1 + 2 + 1 + 1; e.busy_cyc = 1; e.name = "b2b_b";
        q.push_back(e);
        @(negedge clk);
        is_left_shift = 1'b0; mode = 2'b10; amount = 4'd1; data_in = 8'h01;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        start = 1'b0;
        drain("b2b");

        // abort mid-shift with reset: outputs clear at once, partial result dropped
        @(negedge clk);
        is_left_shift = 1'b1; mode = 2'b00; amount = 4'd5; data_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_data", int'(data_out), 0);
        chk("abort_so", int'(shift_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst", 1'b0, 2'b10, 4'd1, 8'b0000_0011, 8'b1000_0001, 1'b1, 1);
        drain("post_rst");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
